// File: rtl/fractal_sync_rsp_dispatch.sv
// Response dispatcher of a fractal sync node: round-robin merge of response
// sources into a registered FIFO, with each head entry broadcast to every child.
module fractal_sync_rsp_dispatch #(
  parameter int N_IN_PORTS  = 2,
  parameter int N_OUT_PORTS = 2,
  parameter int ID_WIDTH    = 1,
  parameter int LVL_WIDTH   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rsp_valid_i   [N_IN_PORTS],
  output logic                 rsp_ready_o   [N_IN_PORTS],
  input  logic [ID_WIDTH-1:0]  rsp_id_i      [N_IN_PORTS],
  input  logic [LVL_WIDTH-1:0] rsp_lvl_i     [N_IN_PORTS],
  output logic                 child_valid_o [N_OUT_PORTS],
  input  logic                 child_ready_i [N_OUT_PORTS],
  output logic [ID_WIDTH-1:0]  child_id_o    [N_OUT_PORTS],
  output logic [LVL_WIDTH-1:0] child_lvl_o   [N_OUT_PORTS],
  output logic [CNT_WIDTH-1:0] occupancy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RR_W  = (N_IN_PORTS > 1) ? $clog2(N_IN_PORTS) : 1;

  if (N_IN_PORTS < 1) begin : g_bad_in
    $fatal(1, "N_IN_PORTS must be >= 1");
  end
  if (N_OUT_PORTS < 1) begin : g_bad_out
    $fatal(1, "N_OUT_PORTS must be >= 1");
  end
  if (ID_WIDTH < 1 || LVL_WIDTH < 1) begin : g_bad_width
    $fatal(1, "ID_WIDTH and LVL_WIDTH must be > 0");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // Handshakes: a transfer happens on a port in any cycle where valid and ready
  // are both high at the clock edge; a valid that is not yet accepted keeps its
  // data stable. Input ready never looks at the same-cycle pop.

  logic [RR_W-1:0]      rr_q;
  logic [RR_W-1:0]      grant_idx;
  logic                 grant_vld;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [ID_WIDTH-1:0]  mem_id  [FIFO_DEPTH];
  logic [LVL_WIDTH-1:0] mem_lvl [FIFO_DEPTH];
  logic [N_OUT_PORTS-1:0] sent_q;
  logic [N_OUT_PORTS-1:0] done;
  logic full, empty, push, pop;

  assign full  = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = grant_vld & ~full;
  assign occupancy_o = cnt_q;

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = rr_q;
    for (int i = 0; i < N_IN_PORTS; i++) begin
      idx = (int'(rr_q) + i) % N_IN_PORTS;
      if (!grant_vld && rsp_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
  end

  for (genvar g = 0; g < N_IN_PORTS; g++) begin : g_ready
    assign rsp_ready_o[g] = push && (grant_idx == RR_W'(g));
  end

  // A child counts as done once it has accepted the head or is accepting it now.
  for (genvar k = 0; k < N_OUT_PORTS; k++) begin : g_child
    assign child_valid_o[k] = ~empty & ~sent_q[k];
    assign child_id_o[k]    = mem_id[rd_ptr_q];
    assign child_lvl_o[k]   = mem_lvl[rd_ptr_q];
    assign done[k]          = sent_q[k] | child_ready_i[k];
  end

  assign pop = ~empty & (&done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sent_q   <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_id[e]  <= '0;
        mem_lvl[e] <= '0;
      end
    end else begin
      if (push) begin
        mem_id[wr_ptr_q]  <= rsp_id_i[grant_idx];
        mem_lvl[wr_ptr_q] <= rsp_lvl_i[grant_idx];
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        rr_q <= (grant_idx == RR_W'(N_IN_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        sent_q   <= '0;
      end else if (!empty) begin
        for (int k = 0; k < N_OUT_PORTS; k++) begin
          if (child_ready_i[k]) sent_q[k] <= 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fractal_sync_rsp_dispatch.sv
// Directed bench for fractal_sync_rsp_dispatch: hand-checked cycle vectors plus
// per-child expected queues that follow every accepted input.
module tb_fractal_sync_rsp_dispatch;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int IW = 4;
  localparam int LW = 2;
  localparam int W  = IW + LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rsp_valid   [NI];
  logic          rsp_ready   [NI];
  logic [IW-1:0] rsp_id      [NI];
  logic [LW-1:0] rsp_lvl     [NI];
  logic          child_valid [NO];
  logic          child_ready [NO];
  logic [IW-1:0] child_id    [NO];
  logic [LW-1:0] child_lvl   [NO];
  logic [3:0]    occupancy;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  fractal_sync_rsp_dispatch #(
    .N_IN_PORTS(NI), .N_OUT_PORTS(NO), .ID_WIDTH(IW), .LVL_WIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready),
    .rsp_id_i(rsp_id), .rsp_lvl_i(rsp_lvl),
    .child_valid_o(child_valid), .child_ready_i(child_ready),
    .child_id_o(child_id), .child_lvl_o(child_lvl),
    .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted input is owed exactly once to each child, in order.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (child_valid[0] && child_ready[0]) begin
        if (exp_q0.size() == 0) check("c0_unexpected", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check("c0_data", {26'd0, child_lvl[0], child_id[0]}, {26'd0, e});
        end
      end
      if (child_valid[1] && child_ready[1]) begin
        if (exp_q1.size() == 0) check("c1_unexpected", 1, 0);
        else begin
          e = exp_q1.pop_front();
          check("c1_data", {26'd0, child_lvl[1], child_id[1]}, {26'd0, e});
        end
      end
      for (int p = 0; p < NI; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          exp_q0.push_back({rsp_lvl[p], rsp_id[p]});
          exp_q1.push_back({rsp_lvl[p], rsp_id[p]});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int p = 0; p < NI; p++) rsp_valid[p] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input int p, input logic [IW-1:0] id, input logic [LW-1:0] lvl);
    int n;
    rsp_valid[p] = 1'b1;
    rsp_id[p]    = id;
    rsp_lvl[p]   = lvl;
    n = 0;
    @(negedge clk);
    while (!rsp_ready[p] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_ready[p]) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    rsp_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (occupancy != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_q0_left"}, exp_q0.size(), 0);
    check({tag, "_q1_left"}, exp_q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int p = 0; p < NI; p++) begin
      rsp_valid[p] = 1'b0; rsp_id[p] = '0; rsp_lvl[p] = '0;
    end
    for (int k = 0; k < NO; k++) child_ready[k] = 1'b0;
    #2;
    check("rst_occ", occupancy, 0);
    check("rst_cv0", child_valid[0], 0);
    check("rst_cv1", child_valid[1], 0);
    check("rst_id", child_id[0], 0);
    do_reset();

    // Single response, no fall-through, one-cycle latency.
    rsp_valid[0] = 1'b1; rsp_id[0] = 4'd1; rsp_lvl[0] = 2'd2;
    child_ready[0] = 1'b1; child_ready[1] = 1'b1;
    @(negedge clk);
    check("t1_rdy0", rsp_ready[0], 1);
    check("t1_rdy1", rsp_ready[1], 0);
    check("t1_no_fallthru", child_valid[0], 0);
    check("t1_occ0", occupancy, 0);
    @(posedge clk); #1 rsp_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_cv0", child_valid[0], 1);
    check("t1_cv1", child_valid[1], 1);
    check("t1_id1", child_id[1], 1);
    check("t1_lvl1", child_lvl[1], 2);
    check("t1_occ1", occupancy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_occ_after", occupancy, 0);
    check("t1_cv0_after", child_valid[0], 0);
    @(posedge clk); #1;

    // Round-robin from pointer 0 with both inputs always valid.
    do_reset();
    rsp_valid[0] = 1'b1; rsp_id[0] = 4'd0; rsp_lvl[0] = 2'd0;
    rsp_valid[1] = 1'b1; rsp_id[1] = 4'd1; rsp_lvl[1] = 2'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rr_rdy0_c%0d", c), rsp_ready[0], (c % 2 == 0) ? 1 : 0);
      check($sformatf("rr_rdy1_c%0d", c), rsp_ready[1], (c % 2 == 1) ? 1 : 0);
      if (c > 0) check($sformatf("rr_occ_c%0d", c), occupancy, 1);
      @(posedge clk); #1;
    end
    rsp_valid[0] = 1'b0; rsp_valid[1] = 1'b0;
    wait_drain("rr");

    // Skewed fork: child0 accepts at cycle 1 and stays ready, child1 at cycle 4.
    do_reset();
    child_ready[0] = 1'b0; child_ready[1] = 1'b0;
    send(0, 4'd5, 2'd1);
    child_ready[0] = 1'b1;
    @(negedge clk);
    check("sk_cv0_c1", child_valid[0], 1);
    check("sk_cv1_c1", child_valid[1], 1);
    @(posedge clk); #1;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("sk_cv0_c%0d", c), child_valid[0], 0);
      check($sformatf("sk_cv1_c%0d", c), child_valid[1], 1);
      check($sformatf("sk_id1_c%0d", c), child_id[1], 5);
      check($sformatf("sk_lvl1_c%0d", c), child_lvl[1], 1);
      @(posedge clk); #1;
    end
    child_ready[1] = 1'b1;
    @(negedge clk);
    check("sk_cv1_c4", child_valid[1], 1);
    check("sk_occ_c4", occupancy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sk_occ_c5", occupancy, 0);
    check("sk_cv0_c5", child_valid[0], 0);
    check("sk_cv1_c5", child_valid[1], 0);
    @(posedge clk); #1;

    // Full FIFO: four accepted, fifth held off until after the first pop.
    do_reset();
    child_ready[0] = 1'b0; child_ready[1] = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, IW'(i), LW'(i));
    rsp_valid[0] = 1'b1; rsp_id[0] = 4'd5; rsp_lvl[0] = 2'd1;
    rsp_valid[1] = 1'b1; rsp_id[1] = 4'd6; rsp_lvl[1] = 2'd2;
    @(negedge clk);
    check("full_occ", occupancy, 4);
    check("full_rdy0", rsp_ready[0], 0);
    check("full_rdy1", rsp_ready[1], 0);
    @(posedge clk); #1;
    rsp_valid[1] = 1'b0;
    child_ready[0] = 1'b1; child_ready[1] = 1'b1;
    @(negedge clk);
    check("full_rdy_on_pop", rsp_ready[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_occ_after_pop", occupancy, 3);
    check("full_rdy_after_pop", rsp_ready[0], 1);
    @(posedge clk); #1 rsp_valid[0] = 1'b0;
    wait_drain("full");

    // Pointer wrap: ten entries streamed through a four-deep buffer.
    do_reset();
    for (int i = 0; i < 10; i++) send(0, IW'(i % 16), LW'(i % 4));
    wait_drain("wrap");

    // Asynchronous reset with three entries queued and the head half-delivered.
    do_reset();
    child_ready[0] = 1'b0; child_ready[1] = 1'b0;
    send(0, 4'd7, 2'd3);
    send(1, 4'd8, 2'd0);
    send(0, 4'd9, 2'd1);
    child_ready[0] = 1'b1;
    @(posedge clk); #1 child_ready[0] = 1'b0;
    @(negedge clk);
    check("mr_occ_before", occupancy, 3);
    check("mr_cv0_sent", child_valid[0], 0);
    check("mr_cv1_pend", child_valid[1], 1);
    #1 rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("mr_occ", occupancy, 0);
    check("mr_cv0", child_valid[0], 0);
    check("mr_cv1", child_valid[1], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    child_ready[0] = 1'b1; child_ready[1] = 1'b1;
    send(1, 4'd3, 2'd1);
    @(negedge clk);
    check("mr_new_cv0", child_valid[0], 1);
    check("mr_new_id0", child_id[0], 3);
    @(posedge clk); #1;
    wait_drain("mr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
